// File: rtl/chunked_adder_pkg.sv
// Shared types and constants for the chunked adder controller: chunk width,
// FSM state encoding and sizing of the chunk index register.
package chunked_adder_pkg;

    localparam int CHUNK_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single chunk still needs a 1-bit index register.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/adder_3_bit.sv
// 3-bit ripple-carry adder datapath consumed by chunked_adder_ctrl.
// Bit 1 is the LSB: A1/B1/S, A2/B2/S2 and A3/B3/S3.
module adder_3_bit (
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic Cin,
    output logic S,
    output logic S2,
    output logic S3,
    output logic Cout
);

    logic c1;
    logic c2;

    assign S    = A1 ^ B1 ^ Cin;
    assign c1   = (A1 & B1) | (Cin & (A1 ^ B1));
    assign S2   = A2 ^ B2 ^ c1;
    assign c2   = (A2 & B2) | (c1 & (A2 ^ B2));
    assign S3   = A3 ^ B3 ^ c2;
    assign Cout = (A3 & B3) | (c2 & (A3 ^ B3));

endmodule

// File: rtl/chunked_adder_ctrl.sv
// Sequential WIDTH-bit adder that walks 3-bit chunks through adder_3_bit, LSB first.
// Define CHUNKED_ADDER_OVF_EN to compute the signed overflow flag; otherwise ovf is tied low.
module chunked_adder_ctrl
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                CHUNKS   = WIDTH / CHUNK_W;
    localparam int                IDX_W    = idx_width(CHUNKS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHUNKS - 1);

    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_width_check
        $error("chunked_adder_ctrl: WIDTH must be a positive multiple of 3");
    end

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry;
    logic               cout_reg;
    logic               last_chunk;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic               s1;
    logic               s2;
    logic               s3;
    logic               c_out;

    assign a_chunk    = a_reg[CHUNK_W*idx +: CHUNK_W];
    assign b_chunk    = b_reg[CHUNK_W*idx +: CHUNK_W];
    assign last_chunk = (idx == LAST_IDX);

    adder_3_bit u_adder (
        .A1   (a_chunk[0]),
        .A2   (a_chunk[1]),
        .A3   (a_chunk[2]),
        .B1   (b_chunk[0]),
        .B2   (b_chunk[1]),
        .B3   (b_chunk[2]),
        .Cin  (carry),
        .S    (s1),
        .S2   (s2),
        .S3   (s3),
        .Cout (c_out)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are only read in RUN after a load.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx   <= '0;
                        carry <= cin;
                    end
                end
                RUN: begin
                    sum_reg[CHUNK_W*idx +: CHUNK_W] <= {s3, s2, s1};
                    carry <= c_out;
                    if (last_chunk) begin
                        idx      <= '0;
                        cout_reg <= c_out;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) idx <= '0;
                end
                default: idx <= '0;
            endcase
        end
    end

`ifdef CHUNKED_ADDER_OVF_EN
    logic ovf_reg;

    // s3 on the final chunk is the result sign bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && last_chunk) begin
            ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s3 != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: doc/chunked_adder_ctrl.md
Name: chunked_adder_ctrl

Overview:
Sequential controller that adds two WIDTH-bit operands by slicing them into 3-bit chunks. It feeds one chunk per cycle to an instance of the existing adder_3_bit. The carry is registered between chunks and the result is assembled LSB-chunk first. It sits directly upstream of adder_3_bit, driving its A1..A3/B1..B3/Cin and consuming S/S2/S3/Cout. Operands arrive and results leave through valid/ready handshakes.

Parameters:
WIDTH, 12, operand/result width in bits; must be a multiple of 3 and >= 3 (elaboration error otherwise)
CHUNKS, WIDTH/3, derived local parameter; number of 3-bit slices (not overridable)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand set a/b/cin is valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into chunk 0
out_valid  output  1  sum/cout valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of MSB chunk
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 once in IDLE.
- Reset mid-operation: same as above. In-flight operation is discarded and no out_valid is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Edge with in_valid=1: latch a, b, cin into internal regs; idx=0; carry reg=cin; go RUN.
- RUN:
  - in_ready=0, out_valid=0. in_valid is ignored.
  - Drive adder_3_bit: A1..A3 = a_reg[3*idx +: 3] (A1=LSB); B likewise from b_reg; Cin = carry reg.
  - Each edge: sum_reg[3*idx +: 3] <= {S3,S2,S}; carry reg <= Cout; idx <= idx+1.
  - On the edge that processes idx==CHUNKS-1: cout <= Cout; go DONE.
- DONE:
  - out_valid=1, in_ready=0. sum/cout/ovf held stable.
  - Edge with out_ready=1: go IDLE, idx=0. sum/cout keep their last value until the next accept overwrites them chunk by chunk.
- Latency: out_valid rises exactly CHUNKS cycles after the accepting edge (4 cycles for WIDTH=12).
- Throughput: one operation per CHUNKS+2 cycles minimum (accept, CHUNKS RUN edges, handoff). There is no overlap between operations.
- Backpressure: out_ready=0 holds DONE indefinitely with outputs stable.
- Width rules: sum wraps modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1. All-ones plus cin=1 gives sum=0, cout=1.
- idx register width is clog2(CHUNKS), minimum 1 bit. idx never exceeds CHUNKS-1.
- WIDTH=3: single RUN cycle; same FSM.

Optional Feature:
Macro: CHUNKED_ADDER_OVF_EN
- Defined: on the final RUN edge, ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (S3 != a_reg[WIDTH-1]), i.e. two's-complement overflow. ovf is valid alongside out_valid and cleared on accept and on reset.
- Undefined: ovf is tied to 0 and no extra logic is present.
- The port exists in both builds.

Decomposition:
- Package chunked_adder_pkg:
  - CHUNK_W=3
  - state enum type (IDLE, RUN, DONE)
  - function computing the idx width from CHUNKS
- Sub-module: one instance of the existing adder_3_bit as the datapath. Do not re-implement the add.
- The controller contains only the FSM, operand/sum/carry registers, and chunk muxing.

Test Plan:
- WIDTH=12, a=0x123, b=0x456, cin=1, out_ready=1 -> sum=0x57A, cout=0; out_valid exactly 4 cycles after accept; in_ready low during RUN/DONE.
- a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1 (carry ripples across all 4 chunks). Also a=0xFFF, b=0x000, cin=1 -> sum=0x000, cout=1.
- Backpressure: a=0x0A5, b=0x05A, cin=0 with out_ready=0 for 6 cycles after out_valid -> sum=0x0FF, cout=0 held stable; in_valid pulses during this window are not accepted; accept resumes the cycle after out_ready=1.
- Reset mid-RUN: assert rst_n=0 for one edge at idx=2 -> next cycle IDLE, out_valid=0, sum=0, cout=0, in_ready=1. No stale result appears afterwards.
- Overflow, macro defined: a=0x7FF, b=0x001 -> sum=0x800, cout=0, ovf=1. a=0x800, b=0xFFF -> sum=0x7FF, cout=1, ovf=1.
- Overflow, macro undefined: same vectors -> ovf=0.
- Exhaustive WIDTH=3 sweep over all 128 {a,b,cin} combinations -> sum/cout match a+b+cin each transaction.
